// File: rtl/fp_iter_divsqrt_multi_wrapper.sv
// Multi-unit front end for iterative FP32 div/sqrt cores: round-robin dispatch, per-unit tag and
// status storage, and a locked output grant that holds results under Valid_o/Ack_i backpressure.

module div_sqrt_top (
    input  logic        Clk_CI,
    input  logic        Rst_RBI,
    input  logic        Div_start_SI,
    input  logic        Sqrt_start_SI,
    input  logic [31:0] Operand_a_DI,
    input  logic [31:0] Operand_b_DI,
    input  logic [1:0]  RM_SI,
    output logic [31:0] Result_DO,
    output logic        Exp_OF_SO,
    output logic        Exp_UF_SO,
    output logic        Div_zero_SO,
    output logic        Ready_SO,
    output logic        Done_SO
);
    localparam logic [31:0] QNan = 32'h7fc00000;

    typedef enum logic [1:0] {CoreIdle, CoreIter, CoreDone} core_state_e;
    core_state_e cst_q, cst_d;

    logic [4:0]         cnt_q;
    logic               is_sqrt_q, sign_q, special_q, dz_q;
    logic [1:0]         rm_q;
    logic signed [10:0] exp_q;
    logic [31:0]        spec_res_q;
    logic [27:0]        rem_q;
    logic [23:0]        mb_q;
    logic [25:0]        quo_q;
    logic [49:0]        rad_q;

    logic [7:0]  a_exp, b_exp;
    logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, start, sgn;
    logic        sp_hit, sp_dz;
    logic [31:0] sp_res;
    logic signed [10:0] ea, eb, exp_div, exp_sqrt;

    assign a_exp  = Operand_a_DI[30:23];
    assign b_exp  = Operand_b_DI[30:23];
    assign a_zero = (a_exp == 8'h00);
    assign b_zero = (b_exp == 8'h00);
    assign a_inf  = (a_exp == 8'hff) && (Operand_a_DI[22:0] == '0);
    assign b_inf  = (b_exp == 8'hff) && (Operand_b_DI[22:0] == '0);
    assign a_nan  = (a_exp == 8'hff) && (Operand_a_DI[22:0] != '0);
    assign b_nan  = (b_exp == 8'hff) && (Operand_b_DI[22:0] != '0);
    assign sgn    = Operand_a_DI[31] ^ Operand_b_DI[31];
    assign start  = (Div_start_SI | Sqrt_start_SI) && (cst_q == CoreIdle);
    assign ea     = $signed({3'b000, a_exp});
    assign eb     = $signed({3'b000, b_exp});
    assign exp_div = ea - eb + 11'sd127;
    // Stored one high so sqrt shares the div "quotient below 1" normalisation path.
    assign exp_sqrt = ((ea - 11'sd127) >>> 1) + 11'sd128;

    // Subnormal inputs are treated as zero.
    always_comb begin
        sp_hit = 1'b1;
        sp_res = '0;
        sp_dz  = 1'b0;
        if (Sqrt_start_SI) begin
            if (a_nan || (Operand_a_DI[31] && !a_zero)) sp_res = QNan;
            else if (a_zero) sp_res = {Operand_a_DI[31], 31'b0};
            else if (a_inf) sp_res = 32'h7f800000;
            else sp_hit = 1'b0;
        end else begin
            if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                sp_res = QNan;
            end else if (a_inf || b_zero) begin
                sp_res = {sgn, 8'hff, 23'b0};
                sp_dz  = b_zero;
            end else if (a_zero || b_inf) begin
                sp_res = {sgn, 31'b0};
            end else begin
                sp_hit = 1'b0;
            end
        end
    end

    logic        d_ge, s_ge, step_bit;
    logic [27:0] d_rem, s_rt, s_trial, s_rem, rem_nx;

    assign d_ge     = rem_q >= {4'b0, mb_q};
    assign d_rem    = d_ge ? rem_q - {4'b0, mb_q} : rem_q;
    assign s_rt     = {rem_q[25:0], rad_q[49:48]};
    assign s_trial  = {1'b0, quo_q[24:0], 2'b01};
    assign s_ge     = s_rt >= s_trial;
    assign s_rem    = s_ge ? s_rt - s_trial : s_rt;
    assign step_bit = is_sqrt_q ? s_ge : d_ge;
    assign rem_nx   = is_sqrt_q ? s_rem : {d_rem[26:0], 1'b0};

    always_comb begin
        cst_d = cst_q;
        unique case (cst_q)
            CoreIdle: if (start) cst_d = CoreIter;
            CoreIter: if (cnt_q == '0) cst_d = CoreDone;
            CoreDone: cst_d = CoreIdle;
            default:  cst_d = CoreIdle;
        endcase
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            cst_q <= CoreIdle;
            cnt_q <= '0; is_sqrt_q <= 1'b0; sign_q <= 1'b0; special_q <= 1'b0; dz_q <= 1'b0;
            rm_q <= '0; exp_q <= '0; spec_res_q <= '0; rem_q <= '0; mb_q <= '0; quo_q <= '0;
            rad_q <= '0;
        end else begin
            cst_q <= cst_d;
            if (start) begin
                is_sqrt_q  <= Sqrt_start_SI;
                sign_q     <= ~Sqrt_start_SI & sgn;
                special_q  <= sp_hit;
                spec_res_q <= sp_res;
                dz_q       <= sp_dz;
                rm_q       <= RM_SI;
                exp_q      <= Sqrt_start_SI ? exp_sqrt : exp_div;
                mb_q       <= {1'b1, Operand_b_DI[22:0]};
                quo_q      <= '0;
                rem_q      <= Sqrt_start_SI ? '0 : {4'b0, 1'b1, Operand_a_DI[22:0]};
                // Odd unbiased exponent (even biased) needs one extra left shift of the radicand.
                rad_q      <= ea[0] ? {1'b0, 1'b1, Operand_a_DI[22:0], 25'b0}
                                    : {1'b1, Operand_a_DI[22:0], 26'b0};
                cnt_q      <= Sqrt_start_SI ? 5'd24 : 5'd25;
            end else if (cst_q == CoreIter) begin
                quo_q <= {quo_q[24:0], step_bit};
                rem_q <= rem_nx;
                rad_q <= {rad_q[47:0], 2'b00};
                cnt_q <= cnt_q - 5'd1;
            end
        end
    end

    logic               hi, g, s, inc, of, uf, ovf_max;
    logic [23:0]        mant;
    logic [24:0]        mr;
    logic [22:0]        frac;
    logic signed [10:0] e0, e1;

    always_comb begin
        hi   = quo_q[25];
        mant = hi ? quo_q[25:2] : quo_q[24:1];
        g    = hi ? quo_q[1] : quo_q[0];
        s    = (hi & quo_q[0]) | (rem_q != '0);
        e0   = hi ? exp_q : exp_q - 11'sd1;
        inc  = 1'b0;
        unique case (rm_q)
            2'd0: inc = g & (s | mant[0]);
            2'd1: inc = 1'b0;
            2'd2: inc = sign_q & (g | s);
            2'd3: inc = ~sign_q & (g | s);
            default: inc = 1'b0;
        endcase
        mr      = {1'b0, mant} + {24'b0, inc};
        e1      = e0 + (mr[24] ? 11'sd1 : 11'sd0);
        frac    = mr[24] ? mr[23:1] : mr[22:0];
        of      = e1 >= 11'sd255;
        uf      = e1 <= 11'sd0;
        ovf_max = (rm_q == 2'd1) || (rm_q == 2'd2 && !sign_q) || (rm_q == 2'd3 && sign_q);
        if (special_q)    Result_DO = spec_res_q;
        else if (of)      Result_DO = ovf_max ? {sign_q, 8'hfe, 23'h7fffff} : {sign_q, 8'hff, 23'h0};
        else if (uf)      Result_DO = {sign_q, 31'b0};  // results below the normal range flush to zero
        else              Result_DO = {sign_q, e1[7:0], frac};
    end

    assign Done_SO     = (cst_q == CoreDone);
    assign Ready_SO    = (cst_q == CoreIdle);
    assign Exp_OF_SO   = Done_SO & ~special_q & of;
    assign Exp_UF_SO   = Done_SO & ~special_q & uf;
    assign Div_zero_SO = Done_SO & special_q & dz_q;
endmodule

module fp_iter_divsqrt_multi_wrapper #(
    parameter int unsigned NUM_UNITS  = 2,
    parameter int unsigned FP_WIDTH   = 32,
    parameter int unsigned TAG_WIDTH  = 5,
    parameter int unsigned RND_WIDTH  = 3,
    parameter int unsigned STAT_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  En_i,
    input  logic [FP_WIDTH-1:0]   OpA_i,
    input  logic [FP_WIDTH-1:0]   OpB_i,
    input  logic                  sqrt_sel_i,
    input  logic [TAG_WIDTH-1:0]  Tag_i,
    input  logic [RND_WIDTH-1:0]  Rnd_i,
    output logic                  Ready_o,
    output logic                  Valid_o,
    output logic [FP_WIDTH-1:0]   Res_o,
    output logic [TAG_WIDTH-1:0]  Tag_o,
    output logic [STAT_WIDTH-1:0] Status_o,
    input  logic                  Ack_i
);
    localparam int unsigned IW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} unit_state_e;
    unit_state_e st_q [NUM_UNITS];
    unit_state_e st_d [NUM_UNITS];

    logic [TAG_WIDTH-1:0] tag_q [NUM_UNITS];
    logic [FP_WIDTH-1:0]  res_q [NUM_UNITS];
    logic [3:0]           stat_q [NUM_UNITS];
    logic [FP_WIDTH-1:0]  core_res [NUM_UNITS];
    logic [NUM_UNITS-1:0] core_ready, core_done, core_of, core_uf, core_dz;
    logic [NUM_UNITS-1:0] div_start, sqrt_start, free, done_vec;
    logic [IW-1:0]        dp_q, op_q, gnt_q, gnt, disp_idx;
    logic                 lock_q, valid, dispatch, drain;
    logic [IW:0]          disp_pick, out_pick;
    logic                 unused_rnd;

    assign unused_rnd = ^Rnd_i;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        if (int'(v) + 1 >= int'(NUM_UNITS)) return '0;
        return v + 1'b1;
    endfunction

    // Returns {found, index} of the first set request at or after ptr.
    function automatic logic [IW:0] rr_pick(input logic [NUM_UNITS-1:0] req,
                                            input logic [IW-1:0] ptr);
        logic          found;
        logic [IW-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < int'(NUM_UNITS); k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= int'(NUM_UNITS)) j = j - int'(NUM_UNITS);
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        for (int i = 0; i < int'(NUM_UNITS); i++) begin
            free[i]     = (st_q[i] == StIdle) && core_ready[i];
            done_vec[i] = (st_q[i] == StDone);
        end
    end

    assign Ready_o   = |free;
    assign dispatch  = En_i & Ready_o;
    assign disp_pick = rr_pick(free, dp_q);
    assign disp_idx  = disp_pick[IW-1:0];
    assign out_pick  = rr_pick(done_vec, op_q);
    // A presented but unacknowledged result keeps the port until it is taken.
    assign gnt       = lock_q ? gnt_q : out_pick[IW-1:0];
    assign valid     = lock_q | out_pick[IW];
    assign drain     = valid & Ack_i;

    always_comb begin
        for (int i = 0; i < int'(NUM_UNITS); i++) begin
            st_d[i]       = st_q[i];
            div_start[i]  = 1'b0;
            sqrt_start[i] = 1'b0;
            unique case (st_q[i])
                StIdle: if (dispatch && disp_idx == IW'(i)) begin
                    st_d[i]       = StBusy;
                    div_start[i]  = ~sqrt_sel_i;
                    sqrt_start[i] = sqrt_sel_i;
                end
                StBusy: if (core_done[i]) st_d[i] = StDone;
                StDone: if (drain && gnt == IW'(i)) st_d[i] = StIdle;
                default: st_d[i] = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NUM_UNITS); i++) begin
                st_q[i]   <= StIdle;
                tag_q[i]  <= '0;
                res_q[i]  <= '0;
                stat_q[i] <= '0;
            end
            dp_q   <= '0;
            op_q   <= '0;
            gnt_q  <= '0;
            lock_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_UNITS); i++) begin
                st_q[i] <= st_d[i];
                if (div_start[i] || sqrt_start[i]) tag_q[i] <= Tag_i;
                if (st_q[i] == StBusy && core_done[i]) begin
                    res_q[i]  <= core_res[i];
                    stat_q[i] <= {core_dz[i], core_of[i], core_uf[i], 1'b0};
                end
            end
            if (dispatch) dp_q <= wrap_inc(disp_idx);
            if (drain) op_q <= wrap_inc(gnt);
            lock_q <= valid & ~Ack_i;
            gnt_q  <= gnt;
        end
    end

    assign Valid_o  = valid;
    assign Res_o    = valid ? res_q[gnt] : '0;
    assign Tag_o    = valid ? tag_q[gnt] : '0;
    assign Status_o = valid ? STAT_WIDTH'(stat_q[gnt]) : '0;

    for (genvar i = 0; i < int'(NUM_UNITS); i++) begin : g_unit
        div_sqrt_top u_core (
            .Clk_CI        (clk_i),
            .Rst_RBI       (rst_ni),
            .Div_start_SI  (div_start[i]),
            .Sqrt_start_SI (sqrt_start[i]),
            .Operand_a_DI  (OpA_i),
            .Operand_b_DI  (OpB_i),
            .RM_SI         (Rnd_i[1:0]),
            .Result_DO     (core_res[i]),
            .Exp_OF_SO     (core_of[i]),
            .Exp_UF_SO     (core_uf[i]),
            .Div_zero_SO   (core_dz[i]),
            .Ready_SO      (core_ready[i]),
            .Done_SO       (core_done[i])
        );
    end
endmodule

// File: tb/tb_fp_iter_divsqrt_multi_wrapper.sv
// Directed self-checking bench for the two-unit FP32 div/sqrt wrapper.

module tb_fp_iter_divsqrt_multi_wrapper;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, sqrt_sel, ack, ready, valid;
    logic [31:0] opa, opb, res;
    logic [4:0]  tag_in, tag_out;
    logic [2:0]  rnd;
    logic [3:0]  status;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp_iter_divsqrt_multi_wrapper #(
        .NUM_UNITS  (2),
        .FP_WIDTH   (32),
        .TAG_WIDTH  (5),
        .RND_WIDTH  (3),
        .STAT_WIDTH (4)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .En_i       (en),
        .OpA_i      (opa),
        .OpB_i      (opb),
        .sqrt_sel_i (sqrt_sel),
        .Tag_i      (tag_in),
        .Rnd_i      (rnd),
        .Ready_o    (ready),
        .Valid_o    (valid),
        .Res_o      (res),
        .Tag_o      (tag_out),
        .Status_o   (status),
        .Ack_i      (ack)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; holds En_i across one rising edge.
    task automatic issue(input logic sq, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t);
        en = 1'b1; sqrt_sel = sq; opa = a; opb = b; tag_in = t;
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            if (valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    bit          ok;
    int          nres;
    logic [4:0]  got_tag [4];
    logic [31:0] got_res [4];

    task automatic collect(input int cycles);
        nres = 0;
        for (int c = 0; c < cycles; c++) begin
            if (valid) begin
                if (nres < 4) begin
                    got_tag[nres] = tag_out;
                    got_res[nres] = res;
                end
                nres++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; sqrt_sel = 1'b0; ack = 1'b0;
        opa = '0; opb = '0; tag_in = '0; rnd = 3'd0;
        repeat (2) @(negedge clk);
        check("reset_valid", valid, 0);
        check("reset_res", res, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_ready", ready, 1);

        // 6 / 2
        ack = 1'b1;
        issue(1'b0, 32'h40C00000, 32'h40000000, 5'd5);
        wait_valid(60, ok);
        check("t1_timeout", ok, 1);
        check("t1_res", res, 32'h40400000);
        check("t1_tag", tag_out, 5);
        check("t1_status", status, 0);
        @(negedge clk);
        check("t1_pulse", valid, 0);

        // sqrt 4
        issue(1'b1, 32'h40800000, 32'h0, 5'd3);
        wait_valid(60, ok);
        check("t2_timeout", ok, 1);
        check("t2_res", res, 32'h40000000);
        check("t2_tag", tag_out, 3);
        check("t2_status", status, 0);
        @(negedge clk);
        // 1 / 0
        issue(1'b0, 32'h3F800000, 32'h00000000, 5'd4);
        wait_valid(60, ok);
        check("t2_dz_timeout", ok, 1);
        check("t2_dz_res", res, 32'h7F800000);
        check("t2_dz_status", status, 4'b1000);
        @(negedge clk);

        // overflow and underflow
        issue(1'b0, 32'h7F7FFFFF, 32'h3F000000, 5'd10);
        wait_valid(60, ok);
        check("t3_of_timeout", ok, 1);
        check("t3_of_res", res, 32'h7F800000);
        check("t3_of_status", status, 4'b0100);
        @(negedge clk);
        issue(1'b0, 32'h00800000, 32'h4B000000, 5'd11);
        wait_valid(60, ok);
        check("t3_uf_timeout", ok, 1);
        check("t3_uf_bit", status[1], 1);
        @(negedge clk);

        // backpressure
        ack = 1'b0;
        issue(1'b0, 32'h40C00000, 32'h40000000, 5'd1);
        issue(1'b0, 32'h40400000, 32'h3F800000, 5'd2);
        check("t4_ready_busy", ready, 0);
        issue(1'b0, 32'h3F800000, 32'h3F800000, 5'd9);
        wait_valid(60, ok);
        check("t4_timeout", ok, 1);
        check("t4_tag1", tag_out, 1);
        check("t4_res1", res, 32'h40400000);
        repeat (5) @(negedge clk);
        check("t4_hold_valid", valid, 1);
        check("t4_hold_tag", tag_out, 1);
        check("t4_ready_done", ready, 0);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("t4_valid2", valid, 1);
        check("t4_tag2", tag_out, 2);
        check("t4_res2", res, 32'h40400000);
        check("t4_ready_after", ready, 1);
        ack = 1'b1;
        @(negedge clk);
        check("t4_drained", valid, 0);
        collect(40);
        check("t4_no_extra", nres, 0);

        // overlap: sqrt 9 then 10 / 5
        issue(1'b1, 32'h41100000, 32'h0, 5'd7);
        issue(1'b0, 32'h41200000, 32'h40A00000, 5'd8);
        collect(80);
        check("t5_count", nres, 2);
        check("t5_tag_a", got_tag[0], 7);
        check("t5_res_a", got_res[0], 32'h40400000);
        check("t5_tag_b", got_tag[1], 8);
        check("t5_res_b", got_res[1], 32'h40000000);

        // reset mid-operation
        ack = 1'b0;
        issue(1'b0, 32'h40C00000, 32'h40000000, 5'd1);
        wait_valid(60, ok);
        check("t6_timeout", ok, 1);
        issue(1'b0, 32'h41200000, 32'h40A00000, 5'd2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", valid, 0);
        check("t6_rst_res", res, 0);
        check("t6_rst_tag", tag_out, 0);
        check("t6_rst_status", status, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_ready", ready, 1);
        ack = 1'b1;
        issue(1'b0, 32'h40400000, 32'h3F800000, 5'd6);
        collect(60);
        check("t6_count", nres, 1);
        check("t6_tag", got_tag[0], 6);
        check("t6_res", got_res[0], 32'h40400000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
